// File: rtl/pwm_duty_uart_rx.sv
// UART 8N1 receiver that holds the last correctly framed byte as a PWM duty value.
// The line is oversampled 16x. The start bit is verified at its middle, and every
// later bit is sampled 16 ticks after the previous sample point.
module pwm_duty_uart_rx #(
  parameter int unsigned CLK_HZ   = 10_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter logic [7:0]  DUTY_RST = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] duty_o,
  output logic       duty_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  // Oversampling divider; must be at least 2 so that IDLE never sees a tick.
  localparam int unsigned DIV = CLK_HZ / (16 * BAUD);
  localparam int unsigned PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCW-1:0] PC_MAX = PCW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic           rx_meta_q;
  logic           rxs_q;
  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [3:0]     s_q, s_d;
  logic [2:0]     b_q, b_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     duty_q, duty_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           tick;

  assign tick = (pc_q == PC_MAX);

  // Next-state logic: prescaler, sample counter, bit framing and duty capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    s_d     = s_q;
    b_d     = b_q;
    shift_d = shift_q;
    duty_d  = duty_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (state_q == S_IDLE || state_q == S_WAIT_IDLE) begin
      pc_d = '0;
    end else if (tick) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end

    if (tick) begin
      s_d = s_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          s_d     = '0;
        end
      end
      S_START: begin
        if (tick && s_q == 4'd7) begin
          s_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            b_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && s_q == 4'd15) begin
          shift_d = {rxs_q, shift_q[7:1]};
          b_d     = b_q + 3'd1;
          s_d     = '0;
          if (b_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && s_q == 4'd15) begin
          s_d = '0;
          if (rxs_q) begin
            duty_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = S_IDLE;
          s_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        s_d     = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Synchronizer and all receiver state; reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      pc_q      <= '0;
      s_q       <= '0;
      b_q       <= '0;
      shift_q   <= '0;
      duty_q    <= DUTY_RST;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      pc_q      <= pc_d;
      s_q       <= s_d;
      b_q       <= b_d;
      shift_q   <= shift_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign duty_o       = duty_q;
  assign duty_valid_o = valid_q;
  assign frame_err_o  = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pwm_duty_uart_rx.sv
// Bench for pwm_duty_uart_rx. The reference model predicts outputs from frame
// start times: each frame yields an outcome at a fixed offset from its falling
// edge, and a busy interval whose end depends on how the frame terminated.
module tb_pwm_duty_uart_rx;

  localparam int unsigned CLK_HZ = 1_280_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int DIV       = int'(CLK_HZ / (16 * BAUD));   // 8
  localparam int BIT       = 16 * DIV;                       // 128 cycles
  localparam int STOP_LAT  = 3 + 152 * DIV;                  // 1219
  localparam int START_LAT = 3 + 8 * DIV;                    // 67
  localparam logic [7:0] DUTY_RST = 8'h5A;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] duty_o;
  logic       duty_valid_o;
  logic       frame_err_o;
  logic       busy_o;

  pwm_duty_uart_rx #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .DUTY_RST(DUTY_RST)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .duty_o      (duty_o),
    .duty_valid_o(duty_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         good;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    int from;
    int upto;
  } win_t;

  ev_t  evq[$];
  win_t wq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_valid_n = 0, exp_err_n = 0;
  int seen_valid_n = 0, seen_err_n = 0;
  int last_valid = -1, prev_valid = -1;
  logic [7:0] model_duty = DUTY_RST;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  // Every cycle, compare the DUT against the model.
  always @(negedge clk_i) begin : cmp
    logic ev_v, ev_e, bz;
    while (wq.size() > 0 && wq[0].upto <= cyc) wq.delete(0);
    ev_v = 1'b0;
    ev_e = 1'b0;
    bz   = 1'b0;
    if (rst_i) begin
      model_duty = DUTY_RST;
    end else begin
      bz = (wq.size() > 0 && wq[0].from <= cyc);
      if (evq.size() > 0 && evq[0].at == cyc) begin
        if (evq[0].good) begin
          ev_v = 1'b1;
          model_duty = evq[0].val;
          exp_valid_n++;
        end else begin
          ev_e = 1'b1;
          exp_err_n++;
        end
        evq.delete(0);
      end
    end
    check("duty_o", int'(duty_o), int'(model_duty));
    check("duty_valid_o", int'(duty_valid_o), int'(ev_v));
    check("frame_err_o", int'(frame_err_o), int'(ev_e));
    check("busy_o", int'(busy_o), int'(bz));
    if (duty_valid_o) begin
      seen_valid_n++;
      prev_valid = last_valid;
      last_valid = cyc;
    end
    if (frame_err_o) seen_err_n++;
  end

  // Advance n rising edges and settle just after the last one.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Send one frame with bit length len; a bad stop holds the line low for
  // len + hold cycles before releasing it.
  task automatic send_frame(input logic [7:0] data, input int len, input bit stop_ok, input int hold);
    int n;
    ev_t e;
    win_t w;
    n = cyc;
    e.at = n + STOP_LAT;
    e.good = stop_ok;
    e.val = data;
    evq.push_back(e);
    w.from = n + 3;
    w.upto = stop_ok ? n + STOP_LAT : n + 10 * len + hold + 3;
    wq.push_back(w);
    rx_i = 1'b0;
    tick_n(len);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      tick_n(len);
    end
    rx_i = stop_ok;
    tick_n(len);
    if (!stop_ok) begin
      if (hold > 0) tick_n(hold);
      rx_i = 1'b1;
    end
  endtask

  task automatic false_start(input int p);
    int n;
    win_t w;
    n = cyc;
    w.from = n + 3;
    w.upto = n + START_LAT;
    wq.push_back(w);
    rx_i = 1'b0;
    tick_n(p);
    rx_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, v0, e0, gap, kind, len;
    win_t w;
    logic [7:0] byte_r;

    rst_i = 1'b1;
    rx_i  = 1'b1;
    tick_n(5);
    check("reset_duty_lit", int'(duty_o), 'h5A);
    check("reset_busy_lit", int'(busy_o), 0);
    rst_i = 1'b0;
    tick_n(20000);
    check("idle_duty_lit", int'(duty_o), 'h5A);
    check("idle_pulses_lit", seen_valid_n + seen_err_n, 0);

    // Good frame
    n0 = cyc;
    send_frame(8'hA5, BIT, 1'b1, 0);
    tick_n(100);
    check("a5_duty_lit", int'(duty_o), 'hA5);
    check("a5_latency_lit", last_valid - n0, 1219);
    check("a5_busy_lit", int'(busy_o), 0);

    // Bad stop bit, line held low afterwards
    e0 = seen_err_n;
    v0 = seen_valid_n;
    send_frame(8'h3C, BIT, 1'b0, 3 * BIT);
    check("bad_busy_at_release", int'(busy_o), 1);
    tick_n(2);
    check("bad_busy_release_p2", int'(busy_o), 1);
    tick_n(1);
    check("bad_busy_release_p3", int'(busy_o), 0);
    tick_n(50);
    check("bad_err_count_lit", seen_err_n - e0, 1);
    check("bad_no_valid_lit", seen_valid_n - v0, 0);
    check("bad_duty_lit", int'(duty_o), 'hA5);

    // False start
    n0 = cyc;
    e0 = seen_err_n;
    v0 = seen_valid_n;
    false_start(37);
    tick_n(START_LAT - 37 - 1);
    check("fs_busy_before_lit", int'(busy_o), 1);
    tick_n(1);
    check("fs_busy_fall_lit", cyc - n0, 67);
    check("fs_busy_after_lit", int'(busy_o), 0);
    tick_n(40);
    check("fs_pulses_lit", (seen_err_n - e0) + (seen_valid_n - v0), 0);
    check("fs_duty_lit", int'(duty_o), 'hA5);

    // Back-to-back frames
    send_frame(8'h00, BIT, 1'b1, 0);
    send_frame(8'hFF, BIT, 1'b1, 0);
    tick_n(100);
    gap = last_valid - prev_valid;
    check_range("b2b_gap", gap, 10 * BIT - 2, 10 * BIT + 2);
    check("b2b_duty_lit", int'(duty_o), 'hFF);

    // Reset during data bit 4 of 0x81
    e0 = seen_err_n;
    v0 = seen_valid_n;
    n0 = cyc;
    w.from = n0 + 3;
    w.upto = n0 + 5 * BIT + BIT / 2;
    wq.push_back(w);
    byte_r = 8'h81;
    rx_i = 1'b0;
    tick_n(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_i = byte_r[i];
      tick_n(BIT);
    end
    rx_i = byte_r[4];
    tick_n(BIT / 2);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    tick_n(4);
    rst_i = 1'b0;
    tick_n(100);
    check("rst_duty_lit", int'(duty_o), 'h5A);
    check("rst_no_pulses_lit", (seen_err_n - e0) + (seen_valid_n - v0), 0);
    send_frame(8'h7E, BIT, 1'b1, 0);
    tick_n(100);
    check("after_rst_duty_lit", int'(duty_o), 'h7E);

    // Randomized traffic with sender baud error up to about 3%
    for (int i = 0; i < 14; i++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(BIT - DIV / 2, BIT + DIV / 2));
      if (kind == 0) begin
        false_start(int'($urandom_range(1, START_LAT - 6)));
        tick_n(START_LAT + int'($urandom_range(0, 200)));
      end else if (kind == 1) begin
        send_frame(8'($urandom), len, 1'b0, int'($urandom_range(0, 3 * BIT)));
        tick_n(4 + int'($urandom_range(0, 200)));
      end else begin
        send_frame(8'($urandom), len, 1'b1, 0);
        if ($urandom_range(0, 1) == 1) tick_n(int'($urandom_range(1, 400)));
      end
    end
    tick_n(STOP_LAT + 50);

    check("valid_total", seen_valid_n, exp_valid_n);
    check("err_total", seen_err_n, exp_err_n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_uart_rx.md
# pwm_duty_uart_rx

UART receiver that sets the PWM duty cycle over a serial line. It accepts 8N1 frames at a fixed baud rate, checks framing, and holds the last good byte as the duty value. Its duty_o output drives the duty input of the PWM generator directly; duty_o changes only on a correctly framed byte.

## Interface

Parameters:
- CLK_HZ, 10_000_000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- DUTY_RST, 8'h00: duty_o value after reset.
- Derived DIV = CLK_HZ / (16*BAUD), integer truncation.
  - Must be at least 2.
  - Defaults give DIV = 65, so one bit lasts 1040 clk_i cycles.

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial input, idle high, asynchronous to clk_i.
- duty_o  out  8  last correctly received byte; connects to the PWM duty input.
- duty_valid_o  out  1  one-cycle pulse in the cycle duty_o takes a new value.
- frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation

- Input synchronizer: two flops on rx_i, both reset to 1. All decisions use the synchronized value rxs.
- Prescaler pc (0..DIV-1):
  - Held at 0 in IDLE and WAIT_IDLE.
  - Otherwise counts up and wraps to 0.
  - tick = (pc == DIV-1).
- Sample counter s (4 bits):
  - Cleared on every state entry.
  - Increments on tick.
- Frame format: LSB first, 8 data bits, 1 stop bit, no parity.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rxs == 0, go to START.
  - START: on tick with s == 7 (mid start bit):
    - rxs == 0: go to DATA with bit index b = 0.
    - rxs == 1: false start; return to IDLE with no output activity.
  - DATA: on tick with s == 15:
    - Shift rxs into the shift register, MSB-side insert, so the first bit ends up at bit 0.
    - Increment b. After the 8th bit (b == 7), go to STOP.
    - Otherwise clear s and stay in DATA.
  - STOP: on tick with s == 15:
    - rxs == 1: duty_o <= shift register, pulse duty_valid_o, go to IDLE.
    - rxs == 0: pulse frame_err_o, leave duty_o unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then go to IDLE. A held-low line (break) never starts a frame.
- duty_o is a register.
  - It holds its value between frames.
  - It is never partially updated.
- No parity, no overrun detection. Back-to-back frames are accepted because STOP returns to IDLE at mid-stop-bit.

## Timing

- Reset values:
  - duty_o = DUTY_RST.
  - duty_valid_o = 0, frame_err_o = 0, busy_o = 0.
  - State IDLE; pc, s, b and shift register = 0.
- Reset mid-frame:
  - Aborts immediately; no duty_valid_o and no frame_err_o.
  - duty_o returns to DUTY_RST.
- Synchronizer latency: 2 cycles from an rx_i edge to rxs.
- Every state transition and output pulse is registered on the sampling clock edge.
- Start verification: 8*DIV cycles after entering START (520 cycles at defaults).
- Stop-bit sample: 8*DIV + 144*DIV = 152*DIV cycles after entering START (9880 cycles at defaults).
  - duty_o and duty_valid_o update on that edge.
  - Roughly 9882 cycles after the falling edge of rx_i.
- Pulse width: duty_valid_o and frame_err_o are high for exactly one cycle per frame. They are never high together.
- busy_o:
  - Rises one cycle after rxs goes low in IDLE.
  - Falls in the cycle after the stop sample on a good frame.
  - Falls on return to IDLE after a false start or WAIT_IDLE.
- Glitch rejection: a low pulse on rx_i shorter than about 8*DIV cycles produces only busy_o activity.
- Timing accuracy: sampling is within ±1 clock of the ideal bit centre. Supports sender baud error of ±3% at defaults.

## Test plan

- Reset: assert rst_i mid-idle.
  - Required: duty_o = DUTY_RST, all pulses 0, busy_o = 0.
  - With rx_i idle, outputs stay constant for 20000 cycles.
- Good frame 0xA5 at 1040 cycles/bit:
  - duty_o = 0xA5.
  - One-cycle duty_valid_o about 9882 cycles after the start edge.
  - frame_err_o never high; busy_o low afterwards.
- Bad stop bit: send 0x3C with the stop bit low, line held low 3000 more cycles.
  - One frame_err_o pulse; duty_o unchanged; no duty_valid_o.
  - busy_o stays high until 2 cycles after rx_i returns high.
- False start: rx_i low for 300 cycles, then high.
  - No pulses; duty_o unchanged.
  - busy_o falls about 522 cycles after the falling edge.
- Back-to-back 0x00 then 0xFF with no idle gap between frames:
  - Two duty_valid_o pulses, 10400 ±2 cycles apart.
  - duty_o = 0x00, then 0xFF.
- Reset mid-data: assert rst_i during bit 4 of a 0x81 frame.
  - No pulses; duty_o = DUTY_RST.
  - A following 0x7E frame is received correctly.
